// File: rtl/dsc_pkg.sv
// Shared types for the dual-slope sequencer: FSM states, error codes and the
// bundle of asynchronous analog status lines brought in from analog_top.
package dsc_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_AZ,
      S_INT,
      S_DEINT,
      S_DONE
   } state_e;

   typedef logic [1:0] err_t;

   localparam err_t ERR_NONE = 2'd0;
   localparam err_t ERR_SAT  = 2'd1;
   localparam err_t ERR_TMO  = 2'd2;
   localparam err_t ERR_REF  = 2'd3;

   // Analog status lines, synchronised together as one vector
   typedef struct packed {
      logic comp;
      logic sat_hi;
      logic sat_lo;
      logic ref_ok;
   } afe_status_t;

   localparam int unsigned AFE_STATUS_W = $bits(afe_status_t);

endpackage

// File: rtl/sync_nff.sv
// N-flop synchroniser for asynchronous level signals, reset value 0.
// Ports:
//   clk_i  in  1      destination clock
//   rst_i  in  1      synchronous reset, active-low
//   d_i    in  WIDTH  asynchronous inputs
//   q_o    out WIDTH  synchronised outputs (STAGES cycles of latency)
module sync_nff #(
   parameter int unsigned WIDTH  = 1,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   // Shift chain; newest sample in the low WIDTH bits
   logic [STAGES*WIDTH-1:0] chain_q;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[(STAGES-1)*WIDTH-1:0], d_i};
      end
   end

   assign q_o = chain_q[STAGES*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/dual_slope_ctrl.sv
// Dual-slope voltmeter sequencer: auto-zero, fixed run-up integrate of vin,
// de-integrate against the opposite-polarity reference while counting, then
// present the signed magnitude over valid/ready.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-low reset
//   start_i                       conversion request (IDLE only)
//   range_cfg_i, mode_cfg_i       configuration, latched on accepted start
//   afe_reset_o, afe_sel_o,       analog front-end controls
//   ref_sign_o, range_sel_o, mode_sel_o
//   comp_i, sat_hi_i, sat_lo_i,   asynchronous analog status
//   ref_ok_i
//   busy_o                        high outside IDLE
//   valid_o, ready_i              result handshake
//   result_o, sign_o, err_o       result payload
module dual_slope_ctrl
   import dsc_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned N_AZ        = 256,
   parameter int unsigned N_INT       = 10000,
   parameter int unsigned N_MAX       = 20000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             range_cfg_i,
   input  logic             mode_cfg_i,
   output logic             afe_reset_o,
   output logic             afe_sel_o,
   output logic             ref_sign_o,
   output logic             range_sel_o,
   output logic             mode_sel_o,
   input  logic             comp_i,
   input  logic             sat_hi_i,
   input  logic             sat_lo_i,
   input  logic             ref_ok_i,
   output logic             busy_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [CNT_W-1:0] result_o,
   output logic             sign_o,
   output logic [1:0]       err_o
);

   localparam logic [CNT_W-1:0] AZ_LAST   = CNT_W'(N_AZ - 1);
   localparam logic [CNT_W-1:0] INT_LAST  = CNT_W'(N_INT - 1);
   localparam logic [CNT_W-1:0] DEINT_MAX = CNT_W'(N_MAX);
   localparam logic [CNT_W-1:0] SYNC_LAT  = CNT_W'(SYNC_STAGES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   afe_status_t      raw_st;
   afe_status_t      sync_st;
   logic             comp_s;
   logic             sat_s;
   logic             ref_ok_s;

   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic             pol;

   // Bring the analog status lines into clk_i
   assign raw_st = '{comp: comp_i, sat_hi: sat_hi_i, sat_lo: sat_lo_i, ref_ok: ref_ok_i};

   sync_nff #(
      .WIDTH  (AFE_STATUS_W),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (raw_st),
      .q_o   (sync_st)
   );

   assign comp_s   = sync_st.comp;
   assign sat_s    = sync_st.sat_hi | sync_st.sat_lo;
   assign ref_ok_s = sync_st.ref_ok;

   // Sequencer; every output is registered alongside the state
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state       <= S_IDLE;
         cnt         <= '0;
         pol         <= 1'b0;
         afe_reset_o <= 1'b1;
         afe_sel_o   <= 1'b0;
         ref_sign_o  <= 1'b0;
         range_sel_o <= 1'b0;
         mode_sel_o  <= 1'b0;
         busy_o      <= 1'b0;
         valid_o     <= 1'b0;
         result_o    <= '0;
         sign_o      <= 1'b0;
         err_o       <= ERR_NONE;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start_i) begin
                  busy_o <= 1'b1;
                  if (!ref_ok_s) begin
                     state    <= S_DONE;
                     valid_o  <= 1'b1;
                     result_o <= '0;
                     sign_o   <= 1'b0;
                     err_o    <= ERR_REF;
                  end else begin
                     state       <= S_AZ;
                     cnt         <= '0;
                     range_sel_o <= range_cfg_i;
                     mode_sel_o  <= mode_cfg_i;
                  end
               end
            end

            S_AZ: begin
               if (cnt == AZ_LAST) begin
                  state       <= S_INT;
                  cnt         <= '0;
                  afe_reset_o <= 1'b0;
                  afe_sel_o   <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            S_INT: begin
               if (sat_s) begin
                  state       <= S_DONE;
                  valid_o     <= 1'b1;
                  result_o    <= '0;
                  sign_o      <= 1'b0;
                  err_o       <= ERR_SAT;
                  afe_reset_o <= 1'b1;
                  afe_sel_o   <= 1'b0;
                  ref_sign_o  <= 1'b0;
               end else if (cnt == INT_LAST) begin
                  // Reference polarity opposes the integrated vin.
                  // cnt restarts at 1 so it counts de-integrate cycles including the current one.
                  state      <= S_DEINT;
                  cnt        <= CNT_ONE;
                  pol        <= comp_s;
                  afe_sel_o  <= 1'b1;
                  ref_sign_o <= comp_s;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            S_DEINT: begin
               if (sat_s) begin
                  state       <= S_DONE;
                  valid_o     <= 1'b1;
                  result_o    <= '0;
                  sign_o      <= 1'b0;
                  err_o       <= ERR_SAT;
                  afe_reset_o <= 1'b1;
                  afe_sel_o   <= 1'b0;
                  ref_sign_o  <= 1'b0;
               end else if (comp_s != pol) begin
                  // Remove the synchroniser latency from the crossing count
                  state       <= S_DONE;
                  valid_o     <= 1'b1;
                  result_o    <= (cnt >= SYNC_LAT) ? (cnt - SYNC_LAT) : '0;
                  sign_o      <= ~pol;
                  err_o       <= ERR_NONE;
                  afe_reset_o <= 1'b1;
                  afe_sel_o   <= 1'b0;
                  ref_sign_o  <= 1'b0;
               end else if (cnt == DEINT_MAX) begin
                  state       <= S_DONE;
                  valid_o     <= 1'b1;
                  result_o    <= DEINT_MAX;
                  sign_o      <= ~pol;
                  err_o       <= ERR_TMO;
                  afe_reset_o <= 1'b1;
                  afe_sel_o   <= 1'b0;
                  ref_sign_o  <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            S_DONE: begin
               // valid_o is always high here, so ready_i alone completes the transfer
               if (ready_i) begin
                  valid_o <= 1'b0;
                  if (mode_sel_o && (err_o == ERR_NONE)) begin
                     state <= S_AZ;
                     cnt   <= '0;
                  end else begin
                     state  <= S_IDLE;
                     busy_o <= 1'b0;
                  end
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Bench for dual_slope_ctrl with a behavioural integrator driving comp_i.
module tb_dual_slope_ctrl;
   import dsc_pkg::*;

   localparam int unsigned CNT_W = 16;
   localparam int unsigned N_AZ  = 4;
   localparam int unsigned N_INT = 100;
   localparam int unsigned N_MAX = 300;
   localparam int unsigned SYNC  = 2;
   localparam int VREF    = 200;
   localparam int SAT_LIM = 1000000;
   localparam int WAIT_LIMIT = 1000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_i, start_i, range_cfg_i, mode_cfg_i, ready_i;
   logic             afe_reset_o, afe_sel_o, ref_sign_o, range_sel_o, mode_sel_o;
   logic             comp_i, sat_hi_i, sat_lo_i, ref_ok_i;
   logic             busy_o, valid_o, sign_o;
   logic [CNT_W-1:0] result_o;
   logic [1:0]       err_o;

   int  checks = 0;
   int  errors = 0;
   int  edges;
   bit  rs_seen;
   int  v = 0;
   int  vin_u = 0;
   bit  sat_force = 1'b0;
   bit  ref_ok_drv = 1'b1;

   dual_slope_ctrl #(
      .CNT_W(CNT_W), .N_AZ(N_AZ), .N_INT(N_INT), .N_MAX(N_MAX), .SYNC_STAGES(SYNC)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
      .range_cfg_i(range_cfg_i), .mode_cfg_i(mode_cfg_i),
      .afe_reset_o(afe_reset_o), .afe_sel_o(afe_sel_o), .ref_sign_o(ref_sign_o),
      .range_sel_o(range_sel_o), .mode_sel_o(mode_sel_o),
      .comp_i(comp_i), .sat_hi_i(sat_hi_i), .sat_lo_i(sat_lo_i), .ref_ok_i(ref_ok_i),
      .busy_o(busy_o), .valid_o(valid_o), .ready_i(ready_i),
      .result_o(result_o), .sign_o(sign_o), .err_o(err_o)
   );

   // Integrator: one step per cycle of whatever the AFE controls select
   always @(negedge clk) begin
      if (afe_reset_o)     v = 0;
      else if (!afe_sel_o) v = v + vin_u;
      else if (ref_sign_o) v = v - VREF;
      else                 v = v + VREF;
   end

   assign comp_i   = (v > 0);
   assign sat_hi_i = sat_force || (v > SAT_LIM);
   assign sat_lo_i = (v < -SAT_LIM);
   assign ref_ok_i = ref_ok_drv;

   initial begin
      #900us;
      $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input bit ok, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
      edges++;
   endtask

   task automatic do_start(input int vin, input bit rng, input bit md);
      @(negedge clk);
      vin_u = vin; range_cfg_i = rng; mode_cfg_i = md; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      edges = 1;
      rs_seen = 1'b0;
   endtask

   task automatic wait_valid();
      while (!valid_o && edges < WAIT_LIMIT) begin
         if (afe_sel_o) rs_seen = ref_sign_o;
         step();
      end
      chk("valid_seen", valid_o == 1'b1, valid_o, 1);
   endtask

   task automatic xfer(input int dly);
      repeat (dly) step();
      @(negedge clk); ready_i = 1'b1;
      @(posedge clk); #1;
      chk("valid_drop", valid_o == 1'b0, valid_o, 0);
      @(negedge clk); ready_i = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_afe_reset"}, afe_reset_o == 1'b1, afe_reset_o, 1);
      chk({tag, "_afe_sel"},   afe_sel_o   == 1'b0, afe_sel_o, 0);
      chk({tag, "_ref_sign"},  ref_sign_o  == 1'b0, ref_sign_o, 0);
      chk({tag, "_range"},     range_sel_o == 1'b0, range_sel_o, 0);
      chk({tag, "_mode"},      mode_sel_o  == 1'b0, mode_sel_o, 0);
      chk({tag, "_busy"},      busy_o      == 1'b0, busy_o, 0);
      chk({tag, "_valid"},     valid_o     == 1'b0, valid_o, 0);
      chk({tag, "_result"},    result_o    == '0,   result_o, 0);
      chk({tag, "_sign"},      sign_o      == 1'b0, sign_o, 0);
      chk({tag, "_err"},       err_o       == ERR_NONE, err_o, 0);
   endtask

   typedef struct {
      int   vin;
      bit   rng;
      int   lo;
      int   hi;
      bit   sgn;
      err_t err;
      bit   rsign;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int   n;
      int   r, mag, vin, lat;
      bit   s, pre;
      err_t e;
      bit   stable;

      // vin in units where VREF=200: ideal count = N_INT*|vin|/VREF = |vin|/2
      vecs[0] = '{vin:  100, rng: 1'b0, lo: 49,  hi: 51,  sgn: 1'b0, err: ERR_NONE, rsign: 1'b1};
      vecs[1] = '{vin:  -50, rng: 1'b1, lo: 24,  hi: 26,  sgn: 1'b1, err: ERR_NONE, rsign: 1'b0};
      vecs[2] = '{vin:  800, rng: 1'b0, lo: 300, hi: 300, sgn: 1'b0, err: ERR_TMO,  rsign: 1'b1};
      vecs[3] = '{vin:    1, rng: 1'b1, lo: 0,   hi: 1,   sgn: 1'b0, err: ERR_NONE, rsign: 1'b1};
      vecs[4] = '{vin:   -1, rng: 1'b0, lo: 0,   hi: 1,   sgn: 1'b1, err: ERR_NONE, rsign: 1'b0};
      vecs[5] = '{vin: -551, rng: 1'b1, lo: 275, hi: 276, sgn: 1'b1, err: ERR_NONE, rsign: 1'b0};
      vecs[6] = '{vin:  399, rng: 1'b0, lo: 199, hi: 200, sgn: 1'b0, err: ERR_NONE, rsign: 1'b1};

      rst_i = 1'b0; start_i = 1'b0; range_cfg_i = 1'b0; mode_cfg_i = 1'b0; ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      @(negedge clk); rst_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Table-driven conversions, single-shot
      foreach (vecs[i]) begin
         do_start(vecs[i].vin, vecs[i].rng, 1'b0);
         wait_valid();
         r = int'(result_o);
         chk("vec_result", r >= vecs[i].lo && r <= vecs[i].hi, r, vecs[i].lo);
         chk("vec_sign",   sign_o == vecs[i].sgn, sign_o, vecs[i].sgn);
         chk("vec_err",    err_o == vecs[i].err, err_o, vecs[i].err);
         chk("vec_rsign",  rs_seen == vecs[i].rsign, rs_seen, vecs[i].rsign);
         chk("vec_range",  range_sel_o == vecs[i].rng, range_sel_o, vecs[i].rng);
         chk("vec_done_afe_reset", afe_reset_o == 1'b1, afe_reset_o, 1);
         lat = (vecs[i].err == ERR_TMO) ? int'(1 + N_AZ + N_INT + N_MAX)
                                        : int'(1 + N_AZ + N_INT + SYNC) + r;
         chk("vec_latency", edges == lat, edges, lat);
         xfer(i % 3);
         chk("vec_busy_idle", busy_o == 1'b0, busy_o, 0);
      end

      // Saturation pulse during run-up
      do_start(100, 1'b0, 1'b0);
      n = 0;
      while (afe_reset_o && n < 50) begin step(); n++; end
      chk("sat_int_entered", afe_reset_o == 1'b0, afe_reset_o, 0);
      repeat (50) step();
      @(negedge clk); sat_force = 1'b1;
      @(negedge clk); sat_force = 1'b0;
      wait_valid();
      chk("sat_err",       err_o == ERR_SAT, err_o, ERR_SAT);
      chk("sat_result",    result_o == '0, result_o, 0);
      chk("sat_afe_reset", afe_reset_o == 1'b1, afe_reset_o, 1);
      chk("sat_early",     edges < int'(1 + N_AZ + N_INT), edges, 1 + N_AZ + N_INT);
      xfer(1);

      // Reference not OK: immediate error result, no conversion
      ref_ok_drv = 1'b0;
      repeat (3) step();
      do_start(100, 1'b0, 1'b0);
      wait_valid();
      chk("ref_latency",   edges <= 2, edges, 2);
      chk("ref_err",       err_o == ERR_REF, err_o, ERR_REF);
      chk("ref_result",    result_o == '0, result_o, 0);
      chk("ref_afe_reset", afe_reset_o == 1'b1, afe_reset_o, 1);
      xfer(0);
      chk("ref_busy_idle", busy_o == 1'b0, busy_o, 0);
      ref_ok_drv = 1'b1;
      repeat (3) step();

      // Continuous mode: back-pressure, then automatic restart
      do_start(100, 1'b1, 1'b1);
      wait_valid();
      r = int'(result_o); s = sign_o; e = err_o;
      stable = 1'b1;
      repeat (20) begin
         step();
         if (!(valid_o && int'(result_o) == r && sign_o == s && err_o == e)) stable = 1'b0;
      end
      chk("cont_stable", stable, stable, 1);
      chk("cont_mode_sel", mode_sel_o == 1'b1, mode_sel_o, 1);
      @(negedge clk); ready_i = 1'b1;
      @(posedge clk); #1;
      ready_i = 1'b0;
      chk("cont_valid_drop", valid_o == 1'b0, valid_o, 0);
      chk("cont_busy",       busy_o == 1'b1, busy_o, 1);
      chk("cont_az_reset",   afe_reset_o == 1'b1, afe_reset_o, 1);
      n = 0;
      while (afe_reset_o && n < 20) begin step(); n++; end
      chk("cont_restart_az_len", n == int'(N_AZ), n, N_AZ);
      n = 0;
      while (!afe_sel_o && n < 200) begin step(); n++; end
      chk("cont_deint_entered", afe_sel_o == 1'b1, afe_sel_o, 1);
      repeat (10) step();
      @(negedge clk); rst_i = 1'b0;
      @(posedge clk); #1;
      check_reset("midrst");
      @(negedge clk); rst_i = 1'b1;
      repeat (3) step();

      // Randomized conversions against the arithmetic reference
      for (int k = 0; k < 12; k++) begin
         mag = 2 * int'($urandom_range(0, 274)) + 1;
         vin = ($urandom_range(0, 1) != 0) ? -mag : mag;
         pre = ($urandom_range(0, 1) != 0);
         @(negedge clk); ready_i = pre;
         do_start(vin, 1'(k % 2), 1'b0);
         wait_valid();
         r = int'(result_o);
         // |result - N_INT*|vin|/VREF| <= 1, in integer form
         chk("rnd_result", (2*VREF*r - 2*int'(N_INT)*mag) <= 2*VREF &&
                           (2*int'(N_INT)*mag - 2*VREF*r) <= 2*VREF, r, mag / 2);
         chk("rnd_sign",  sign_o == (vin < 0), sign_o, vin < 0);
         chk("rnd_rsign", rs_seen == (vin > 0), rs_seen, vin > 0);
         chk("rnd_err",   err_o == ERR_NONE, err_o, ERR_NONE);
         lat = int'(1 + N_AZ + N_INT + SYNC) + r;
         chk("rnd_latency", edges == lat, edges, lat);
         if (pre) begin
            step();
            chk("rnd_pre_ready_drop", valid_o == 1'b0, valid_o, 0);
            @(negedge clk); ready_i = 1'b0;
         end else begin
            xfer(int'($urandom_range(0, 5)));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
